// File: rtl/axil_pkg.sv
// ============================================================================
//  Module   : axil_pkg
//  Purpose  : Shared response codes, FSM state encoding and counter helpers
//             for the AXI-Lite write-path router.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_pkg;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  localparam int c_cnt_width = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_FWD    = 3'd2,
    ST_WAIT_B = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic logic [c_cnt_width-1:0] sat_inc(input logic [c_cnt_width-1:0] v);
    return (&v) ? v : v + c_cnt_width'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_addr_match.sv
// ============================================================================
//  Module   : axil_addr_match
//  Purpose  : Window compare of one address against every slave window and
//             lowest-index priority encode to a one-hot select plus miss flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_addr_match #(
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = '0,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE =
    {NUMBER_SLAVE{AXI_ADDR_WIDTH'(1)}}
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [NUMBER_SLAVE-1:0]   hit,
  output logic                      miss
);

  logic [NUMBER_SLAVE-1:0] w_raw_hit;

  // Window end is formed one bit wider so a window touching the top of the
  // address space does not wrap to zero.
  for (genvar i = 0; i < NUMBER_SLAVE; i++) begin : g_win
    logic [AXI_ADDR_WIDTH:0] w_base;
    logic [AXI_ADDR_WIDTH:0] w_end;
    logic [AXI_ADDR_WIDTH:0] w_addr;
    assign w_base       = {1'b0, AXI_ADDR_OFFSET[i]};
    assign w_end        = w_base + {1'b0, AXI_ADDR_RANGE[i]};
    assign w_addr       = {1'b0, addr};
    assign w_raw_hit[i] = (w_addr >= w_base) && (w_addr < w_end);
  end

  logic w_found;

  always_comb begin
    hit     = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUMBER_SLAVE; i++) begin
      if (w_raw_hit[i] && !w_found) begin
        hit[i]  = 1'b1;
        w_found = 1'b1;
      end
    end
    miss = !w_found;
  end

endmodule

`default_nettype wire

// File: rtl/axil_wr_router.sv
// ============================================================================
//  Module   : axil_wr_router
//  Purpose  : AXI-Lite write router: one outstanding AW+W, address decode to
//             N slaves, internal DECERR for holes, watchdog SLVERR on stalls.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_wr_router
  import axil_pkg::*;
#(
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = '0,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE =
    {NUMBER_SLAVE{AXI_ADDR_WIDTH'(1)}},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic [2:0]                    s_axil_awprot,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
  output logic [2:0]                    m_axil_awprot,
  output logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
  output logic [NUMBER_SLAVE-1:0]       m_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]       m_axil_awready,
  output logic [NUMBER_SLAVE-1:0]       m_axil_wvalid,
  input  logic [NUMBER_SLAVE-1:0]       m_axil_wready,
  input  logic [2*NUMBER_SLAVE-1:0]     m_axil_bresp,
  input  logic [NUMBER_SLAVE-1:0]       m_axil_bvalid,
  output logic [NUMBER_SLAVE-1:0]       m_axil_bready,
  output logic                          busy,
  output logic [c_cnt_width-1:0]        decerr_count,
  output logic [c_cnt_width-1:0]        timeout_count
);

  state_t                        r_state;
  state_t                        w_state_next;
  logic [AXI_ADDR_WIDTH-1:0]     r_addr;
  logic [2:0]                    r_prot;
  logic [AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic [NUMBER_SLAVE-1:0]       r_sel;
  logic                          r_aw_done;
  logic                          r_w_done;
  logic [1:0]                    r_bresp;
  logic [31:0]                   r_wd;
  logic [c_cnt_width-1:0]        r_decerr_cnt;
  logic [c_cnt_width-1:0]        r_timeout_cnt;

  logic [NUMBER_SLAVE-1:0]       w_hit;
  logic                          w_miss;
  logic                          w_accept;
  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_b_hs;
  logic                          w_wd_expire;
  logic                          w_timeout;
  logic [1:0]                    w_slave_bresp;

  axil_addr_match #(
    .NUMBER_SLAVE    (NUMBER_SLAVE),
    .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
    .AXI_ADDR_OFFSET (AXI_ADDR_OFFSET),
    .AXI_ADDR_RANGE  (AXI_ADDR_RANGE)
  ) u_addr_match (
    .addr (r_addr),
    .hit  (w_hit),
    .miss (w_miss)
  );

  assign w_accept = (r_state == ST_IDLE) && s_axil_awvalid && s_axil_wvalid;
  assign w_aw_hs  = (r_state == ST_FWD) && !r_aw_done && |(r_sel & m_axil_awready);
  assign w_w_hs   = (r_state == ST_FWD) && !r_w_done && |(r_sel & m_axil_wready);
  assign w_b_hs   = (r_state == ST_WAIT_B) && |(r_sel & m_axil_bvalid);

  // A real B arriving on the expiry cycle wins over the watchdog.
  assign w_wd_expire = (TIMEOUT_CYCLES != 0)
                     && ((r_state == ST_FWD) || (r_state == ST_WAIT_B))
                     && ((r_wd + 32'd1) == 32'(TIMEOUT_CYCLES));
  assign w_timeout   = w_wd_expire && !w_b_hs;

  always_comb begin
    w_slave_bresp = 2'b00;
    for (int i = 0; i < NUMBER_SLAVE; i++) begin
      if (r_sel[i]) w_slave_bresp = w_slave_bresp | m_axil_bresp[2*i +: 2];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    m_axil_awvalid = '0;
    m_axil_wvalid  = '0;
    m_axil_bready  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          s_axil_awready = 1'b1;
          s_axil_wready  = 1'b1;
          w_state_next   = ST_DECODE;
        end
      end
      ST_DECODE: w_state_next = w_miss ? ST_RESP : ST_FWD;
      ST_FWD: begin
        m_axil_awvalid = r_aw_done ? '0 : r_sel;
        m_axil_wvalid  = r_w_done  ? '0 : r_sel;
        if (w_timeout)
          w_state_next = ST_RESP;
        else if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
          w_state_next = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        m_axil_bready = r_sel;
        if (w_b_hs || w_timeout) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        s_axil_bvalid = 1'b1;
        if (s_axil_bready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_addr        <= '0;
      r_prot        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_sel         <= '0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_bresp       <= c_resp_okay;
      r_wd          <= '0;
      r_decerr_cnt  <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= s_axil_awaddr;
        r_prot  <= s_axil_awprot;
        r_wdata <= s_axil_wdata;
        r_wstrb <= s_axil_wstrb;
      end
      if (r_state == ST_DECODE) begin
        r_sel     <= w_hit;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_wd      <= '0;
        if (w_miss) begin
          r_bresp      <= c_resp_decerr;
          r_decerr_cnt <= sat_inc(r_decerr_cnt);
        end
      end
      if ((r_state == ST_FWD) || (r_state == ST_WAIT_B)) r_wd <= r_wd + 32'd1;
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_b_hs)  r_bresp   <= w_slave_bresp;
      if (w_timeout) begin
        r_bresp       <= c_resp_slverr;
        r_timeout_cnt <= sat_inc(r_timeout_cnt);
      end
    end
  end

  assign m_axil_awaddr = r_addr;
  assign m_axil_awprot = r_prot;
  assign m_axil_wdata  = r_wdata;
  assign m_axil_wstrb  = r_wstrb;
  assign s_axil_bresp  = r_bresp;
  assign busy          = (r_state != ST_IDLE);
  assign decerr_count  = r_decerr_cnt;
  assign timeout_count = r_timeout_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axil_wr_router.sv
// ============================================================================
//  Module   : tb_axil_wr_router
//  Purpose  : Directed self-checking bench for axil_wr_router (decode, DECERR,
//             split handshakes, watchdog, overlap/top-of-space windows, reset).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_wr_router;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // ---- DUT 1: four 4 KiB windows, short watchdog ----
  logic [31:0] s_awaddr = '0;
  logic [2:0]  s_awprot = '0;
  logic        s_awvalid = 1'b0, s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready = 1'b0;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [3:0]  m_awvalid, m_awready = '0, m_wvalid, m_wready = '0;
  logic [7:0]  m_bresp = '0;
  logic [3:0]  m_bvalid = '0, m_bready;
  logic        busy;
  logic [15:0] decerr_count, timeout_count;

  axil_wr_router #(
    .NUMBER_SLAVE    (4),
    .AXI_ADDR_WIDTH  (32),
    .AXI_DATA_WIDTH  (32),
    .AXI_ADDR_OFFSET ({32'h3000, 32'h2000, 32'h1000, 32'h0000}),
    .AXI_ADDR_RANGE  ({4{32'h1000}}),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .aclk (aclk), .aresetn (aresetn),
    .s_axil_awaddr (s_awaddr), .s_axil_awprot (s_awprot),
    .s_axil_awvalid (s_awvalid), .s_axil_awready (s_awready),
    .s_axil_wdata (s_wdata), .s_axil_wstrb (s_wstrb),
    .s_axil_wvalid (s_wvalid), .s_axil_wready (s_wready),
    .s_axil_bresp (s_bresp), .s_axil_bvalid (s_bvalid), .s_axil_bready (s_bready),
    .m_axil_awaddr (m_awaddr), .m_axil_awprot (m_awprot),
    .m_axil_wdata (m_wdata), .m_axil_wstrb (m_wstrb),
    .m_axil_awvalid (m_awvalid), .m_axil_awready (m_awready),
    .m_axil_wvalid (m_wvalid), .m_axil_wready (m_wready),
    .m_axil_bresp (m_bresp), .m_axil_bvalid (m_bvalid), .m_axil_bready (m_bready),
    .busy (busy), .decerr_count (decerr_count), .timeout_count (timeout_count)
  );

  // ---- DUT 2: overlapping windows and a window at the top of the space ----
  logic [31:0] s2_awaddr = '0;
  logic        s2_valid = 1'b0, s2_awready, s2_wready;
  logic [1:0]  s2_bresp;
  logic        s2_bvalid;
  logic [31:0] m2_awaddr, m2_wdata;
  logic [2:0]  m2_awprot;
  logic [3:0]  m2_wstrb;
  logic [2:0]  m2_awvalid, m2_wvalid, m2_bready;
  logic        busy2;
  logic [15:0] decerr_count2, timeout_count2;

  axil_wr_router #(
    .NUMBER_SLAVE    (3),
    .AXI_ADDR_WIDTH  (32),
    .AXI_DATA_WIDTH  (32),
    .AXI_ADDR_OFFSET ({32'hFFFF_F000, 32'h1000, 32'h0000}),
    .AXI_ADDR_RANGE  ({32'h1000, 32'h1000, 32'h2000}),
    .TIMEOUT_CYCLES  (16)
  ) dut2 (
    .aclk (aclk), .aresetn (aresetn),
    .s_axil_awaddr (s2_awaddr), .s_axil_awprot (3'b000),
    .s_axil_awvalid (s2_valid), .s_axil_awready (s2_awready),
    .s_axil_wdata (32'hA5A5_0000), .s_axil_wstrb (4'hF),
    .s_axil_wvalid (s2_valid), .s_axil_wready (s2_wready),
    .s_axil_bresp (s2_bresp), .s_axil_bvalid (s2_bvalid), .s_axil_bready (1'b1),
    .m_axil_awaddr (m2_awaddr), .m_axil_awprot (m2_awprot),
    .m_axil_wdata (m2_wdata), .m_axil_wstrb (m2_wstrb),
    .m_axil_awvalid (m2_awvalid), .m_axil_awready (3'b111),
    .m_axil_wvalid (m2_wvalid), .m_axil_wready (3'b111),
    .m_axil_bresp (6'b000000), .m_axil_bvalid (3'b111), .m_axil_bready (m2_bready),
    .busy (busy2), .decerr_count (decerr_count2), .timeout_count (timeout_count2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Presents AW+W for one cycle (T0); returns one cycle later in DECODE (T1).
  task automatic accept1(input logic [31:0] addr, input logic [31:0] data);
    s_awaddr = addr; s_wdata = data; s_wstrb = 4'hF; s_awprot = 3'b010;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    chk("awready_on_accept", s_awready, 1'b1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic accept2(input logic [31:0] addr);
    s2_awaddr = addr; s2_valid = 1'b1;
    tick();
    s2_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_bvalid", s_bvalid, 1'b0);
    chk("rst_bresp", s_bresp, 2'b00);
    chk("rst_m_awvalid", m_awvalid, 4'h0);
    chk("rst_decerr", decerr_count, 16'h0);
    aresetn = 1'b1;
    tick();

    // Hit on slave 1, all slaves ready immediately, OKAY response.
    m_awready = 4'hF; m_wready = 4'hF;
    m_bresp   = 8'b11_10_00_10;
    accept1(32'h1004, 32'hDEAD_BEEF);
    chk("t1_busy_decode", busy, 1'b1);
    chk("t1_awready_low", s_awready, 1'b0);
    tick();                                   // T2
    chk("t1_awvalid", m_awvalid, 4'b0010);
    chk("t1_wvalid", m_wvalid, 4'b0010);
    chk("t1_awaddr", m_awaddr, 32'h1004);
    chk("t1_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("t1_awprot", m_awprot, 3'b010);
    tick();                                   // T3 WAIT_B
    chk("t1_awvalid_drop", m_awvalid, 4'h0);
    chk("t1_bready", m_bready, 4'b0010);
    m_bvalid = 4'b0010;
    tick();                                   // T4
    chk("t1_s_bvalid", s_bvalid, 1'b1);
    chk("t1_bresp", s_bresp, 2'b00);
    m_bvalid = 4'h0; s_bready = 1'b1;
    tick();                                   // T5
    chk("t1_idle", busy, 1'b0);
    chk("t1_bvalid_clear", s_bvalid, 1'b0);
    s_bready = 1'b0;

    // Unmapped address: DECERR at T2, no downstream activity.
    accept1(32'h8000, 32'h1111_2222);
    tick();                                   // T2
    chk("t2_no_awvalid", m_awvalid, 4'h0);
    chk("t2_s_bvalid", s_bvalid, 1'b1);
    chk("t2_bresp", s_bresp, 2'b11);
    chk("t2_decerr_cnt", decerr_count, 16'd1);
    s_bready = 1'b1;
    tick();
    chk("t2_idle", busy, 1'b0);
    s_bready = 1'b0;

    // Slave 2: AW accepted at T2, W at T5, SLVERR from slave.
    m_awready = 4'b0100; m_wready = 4'h0;
    accept1(32'h2010, 32'h0BAD_F00D);
    tick();                                   // T2
    chk("t3_awvalid_t2", m_awvalid, 4'b0100);
    chk("t3_wvalid_t2", m_wvalid, 4'b0100);
    tick();                                   // T3
    m_awready = 4'h0;
    chk("t3_awvalid_t3", m_awvalid, 4'h0);
    chk("t3_wvalid_t3", m_wvalid, 4'b0100);
    tick();                                   // T4
    chk("t3_wvalid_t4", m_wvalid, 4'b0100);
    tick();                                   // T5
    chk("t3_wvalid_t5", m_wvalid, 4'b0100);
    chk("t3_bready_t5", m_bready, 4'h0);
    m_wready = 4'b0100;
    tick();                                   // T6 WAIT_B
    m_wready = 4'h0;
    chk("t3_wvalid_t6", m_wvalid, 4'h0);
    chk("t3_bready_t6", m_bready, 4'b0100);
    m_bresp = 8'b00_10_00_00; m_bvalid = 4'b0100;
    tick();
    m_bvalid = 4'h0;
    chk("t3_s_bvalid", s_bvalid, 1'b1);
    chk("t3_bresp", s_bresp, 2'b10);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;

    // Watchdog: slave 0 never responds; 8 cycles in FWD/WAIT_B then SLVERR.
    m_awready = 4'hF; m_wready = 4'hF; m_bresp = 8'h00;
    accept1(32'h0040, 32'h5555_AAAA);
    repeat (8) tick();                        // T9
    chk("t4_no_resp_t9", s_bvalid, 1'b0);
    chk("t4_bready_t9", m_bready, 4'b0001);
    tick();                                   // T10
    chk("t4_s_bvalid", s_bvalid, 1'b1);
    chk("t4_bresp", s_bresp, 2'b10);
    chk("t4_timeout_cnt", timeout_count, 16'd1);
    m_bvalid = 4'b0001;
    #1;
    chk("t4_late_b_ignored", m_bready, 4'h0);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0; m_bvalid = 4'h0;

    // Next write serviced normally (slave 3, B already waiting).
    m_bvalid = 4'b1000;
    accept1(32'h3FFC, 32'h1234_5678);
    tick();                                   // T2
    chk("t5_awvalid", m_awvalid, 4'b1000);
    tick(); tick();                           // T4
    chk("t5_s_bvalid", s_bvalid, 1'b1);
    chk("t5_bresp", s_bresp, 2'b00);
    chk("t5_decerr_cnt", decerr_count, 16'd1);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0; m_bvalid = 4'h0;

    // Lone AW for 10 cycles is never accepted.
    s_awaddr = 32'h1000; s_awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t6_lone_aw_ready", s_awready, 1'b0);
      tick();
    end
    chk("t6_lone_aw_busy", busy, 1'b0);
    s_awvalid = 1'b0;

    // Reset while waiting for B aborts the transaction.
    accept1(32'h1000, 32'hCAFE_0001);
    tick(); tick();                           // T3 WAIT_B
    chk("t7_bready_before_rst", m_bready, 4'b0010);
    aresetn = 1'b0;
    tick();
    chk("t7_rst_busy", busy, 1'b0);
    chk("t7_rst_bready", m_bready, 4'h0);
    chk("t7_rst_bvalid", s_bvalid, 1'b0);
    chk("t7_rst_timeout_cnt", timeout_count, 16'd0);
    chk("t7_rst_decerr_cnt", decerr_count, 16'd0);
    aresetn = 1'b1;
    tick();

    // Overlap: 0x1800 lies in both slave 0 and slave 1 windows.
    accept2(32'h0000_1800);
    tick();
    chk("t8_overlap_sel", m2_awvalid, 3'b001);
    repeat (3) tick();
    chk("t8_idle", busy2, 1'b0);

    // Top-of-space window must not wrap.
    accept2(32'hFFFF_FFFC);
    tick();
    chk("t9_top_sel", m2_awvalid, 3'b100);
    repeat (3) tick();

    // Just past the overlapping windows: miss.
    accept2(32'h0000_2000);
    tick();
    chk("t10_miss_bresp", s2_bresp, 2'b11);
    chk("t10_miss_cnt", decerr_count2, 16'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
